// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : PS/2 keyboard receiver and TurfWars key-code mapper (CLOCK_50).
//            Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [4:0] IDLE_CODE      = 5'd31
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [4:0] KEY_PRESSED,
    output logic       key_valid,
    output logic       frame_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    localparam logic [16:0] C_TMO_LAST  = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  C_STOP_BIT  = 4'd9;
    localparam logic [3:0]  C_BITCNT_MAX = 4'd10;
    localparam logic [7:0]  C_PFX_EXT   = 8'hE0;
    localparam logic [7:0]  C_PFX_BRK   = 8'hF0;

    rx_state_t   state_q, state_d;
    logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [9:0]  shreg_q, shreg_d;
    logic [16:0] tmo_q, tmo_d;
    logic        byte_rdy_q, byte_rdy_d;
    logic [7:0]  byte_q, byte_d;
    logic        bad_q, bad_d;
    logic        ext_q, ext_d, brk_q, brk_d;
    logic [4:0]  key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic        frame_error_q, frame_error_d;

    logic        w_fall;
    logic        w_frame_ok;
    logic        w_tmo_err;
    logic        w_map_hit;
    logic [4:0]  w_map_code;

    assign w_fall = clk_prev_q & ~clk_s2_q;

`ifdef PS2_PARITY_CHECK_EN
    assign w_frame_ok = shreg_q[9] & (^shreg_q[8:0]);
`else
    assign w_frame_ok = shreg_q[9];
`endif

    // Receiver: synchroniser, deframing FSM and mid-frame timeout
    always_comb begin
        clk_s1_d   = PS2_CLK;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = PS2_DAT;
        dat_s2_d   = dat_s1_q;
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        tmo_d      = tmo_q;
        byte_rdy_d = 1'b0;
        byte_d     = byte_q;
        bad_d      = 1'b0;
        w_tmo_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (w_fall && !dat_s2_q) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (w_fall) begin
                    shreg_d  = {dat_s2_q, shreg_q[9:1]};
                    tmo_d    = '0;
                    bitcnt_d = (bitcnt_q == C_BITCNT_MAX) ? C_BITCNT_MAX : bitcnt_q + 4'd1;
                    if (bitcnt_q == C_STOP_BIT) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    state_d   = ST_IDLE;
                    tmo_d     = '0;
                    w_tmo_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 17'd1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (w_frame_ok) begin
                    byte_rdy_d = 1'b1;
                    byte_d     = shreg_q[7:0];
                end else begin
                    bad_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Make-code table; the extended flag is part of the lookup key
    always_comb begin
        w_map_hit  = 1'b1;
        w_map_code = '0;
        case ({ext_q, byte_q})
            9'h01D: w_map_code = 5'd0;
            9'h01B: w_map_code = 5'd1;
            9'h01C: w_map_code = 5'd2;
            9'h023: w_map_code = 5'd3;
            9'h02C: w_map_code = 5'd4;
            9'h034: w_map_code = 5'd5;
            9'h02B: w_map_code = 5'd6;
            9'h033: w_map_code = 5'd7;
            9'h043: w_map_code = 5'd8;
            9'h042: w_map_code = 5'd9;
            9'h03B: w_map_code = 5'd10;
            9'h04B: w_map_code = 5'd11;
            9'h175: w_map_code = 5'd12;
            9'h172: w_map_code = 5'd13;
            9'h16B: w_map_code = 5'd14;
            9'h174: w_map_code = 5'd15;
            9'h029: w_map_code = 5'd16;
            default: w_map_hit = 1'b0;
        endcase
    end

    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_d         = key_q;
        key_valid_d   = 1'b0;
        frame_error_d = bad_q | w_tmo_err;
        if (byte_rdy_q) begin
            if (byte_q == C_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == C_PFX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (w_map_hit) begin
                    if (brk_q) begin
                        // A break only releases the key currently shown
                        if (key_q == w_map_code) begin
                            key_d = IDLE_CODE;
                        end
                    end else begin
                        key_d       = w_map_code;
                        key_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            state_q       <= ST_IDLE;
            bitcnt_q      <= '0;
            shreg_q       <= '0;
            tmo_q         <= '0;
            byte_rdy_q    <= 1'b0;
            byte_q        <= '0;
            bad_q         <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_q         <= IDLE_CODE;
            key_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_prev_q    <= clk_prev_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            tmo_q         <= tmo_d;
            byte_rdy_q    <= byte_rdy_d;
            byte_q        <= byte_d;
            bad_q         <= bad_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign KEY_PRESSED = key_q;
    assign key_valid   = key_valid_q;
    assign frame_error = frame_error_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Directed self-checking bench for ps2_key_decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_decoder;

    localparam int HALF = 10;
    localparam int NV   = 24;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [4:0] key_pressed;
    logic       key_valid;
    logic       frame_error;

    int tests = 0;
    int fails = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    int overlap = 0;
    int long_pulse = 0;
    logic kv_prev = 1'b0;
    logic fe_prev = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         flip_par;
        bit         bad_stop;
        logic [4:0] exp_key;
        int         exp_kv;
        int         exp_fe;
    } vec_t;

    vec_t vecs [NV];

    ps2_key_decoder dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .KEY_PRESSED (key_pressed),
        .key_valid   (key_valid),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) kv_cnt <= kv_cnt + 1;
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (key_valid && frame_error) overlap <= overlap + 1;
        if ((key_valid && kv_prev) || (frame_error && fe_prev)) long_pulse <= long_pulse + 1;
        kv_prev <= key_valid;
        fe_prev <= frame_error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sends the first nbits of an 11-bit frame (start, data LSB-first, parity, stop)
    task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^data) ^ flip_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    initial begin
        int kv0;
        int fe0;
        int cyc;
        logic [4:0] k_after_par;

`ifdef PS2_PARITY_CHECK_EN
        k_after_par = 5'd0;
        vecs[17] = '{8'h29, 1'b1, 1'b0, 5'd0, 0, 1};
`else
        k_after_par = 5'd16;
        vecs[17] = '{8'h29, 1'b1, 1'b0, 5'd16, 1, 0};
`endif
        vecs[0]  = '{8'hE0, 1'b0, 1'b0, 5'd0,  0, 0};
        vecs[1]  = '{8'h75, 1'b0, 1'b0, 5'd12, 1, 0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 5'd12, 0, 0};
        vecs[3]  = '{8'h75, 1'b0, 1'b0, 5'd12, 0, 0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 5'd12, 0, 0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 5'd12, 0, 0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 5'd31, 0, 0};
        vecs[7]  = '{8'h23, 1'b0, 1'b0, 5'd3,  1, 0};
        vecs[8]  = '{8'h23, 1'b0, 1'b0, 5'd3,  1, 0};
        vecs[9]  = '{8'h1C, 1'b0, 1'b0, 5'd2,  1, 0};
        vecs[10] = '{8'hF0, 1'b0, 1'b0, 5'd2,  0, 0};
        vecs[11] = '{8'h23, 1'b0, 1'b0, 5'd2,  0, 0};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 5'd2,  0, 0};
        vecs[13] = '{8'h1C, 1'b0, 1'b0, 5'd31, 0, 0};
        vecs[14] = '{8'hE0, 1'b0, 1'b0, 5'd31, 0, 0};
        vecs[15] = '{8'h1D, 1'b0, 1'b0, 5'd31, 0, 0};
        vecs[16] = '{8'h1D, 1'b0, 1'b0, 5'd0,  1, 0};
        vecs[18] = '{8'h2C, 1'b0, 1'b1, k_after_par, 0, 1};
        vecs[19] = '{8'h34, 1'b0, 1'b0, 5'd5,  1, 0};
        vecs[20] = '{8'hE1, 1'b0, 1'b0, 5'd5,  0, 0};
        vecs[21] = '{8'h74, 1'b0, 1'b0, 5'd5,  0, 0};
        vecs[22] = '{8'hE0, 1'b0, 1'b0, 5'd5,  0, 0};
        vecs[23] = '{8'h74, 1'b0, 1'b0, 5'd15, 1, 0};

        rst     = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_key", 32'(key_pressed), 32'd31);
        check("reset_kv", 32'(key_valid), 32'd0);
        check("reset_fe", 32'(frame_error), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // First frame 0x1D with exact S+2 latency on the stop bit
        send_frame(8'h1D, 1'b0, 1'b0, 10);
        @(negedge clk);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("lat_pre_kv", 32'(key_valid), 32'd0);
        check("lat_pre_key", 32'(key_pressed), 32'd31);
        @(posedge clk);
        #1;
        check("lat_kv", 32'(key_valid), 32'd1);
        check("lat_key", 32'(key_pressed), 32'd0);
        @(posedge clk);
        #1;
        check("lat_post_kv", 32'(key_valid), 32'd0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop, 11);
            repeat (8) @(negedge clk);
            check($sformatf("vec%0d_key", i), 32'(key_pressed), 32'(vecs[i].exp_key));
            check($sformatf("vec%0d_kv", i), kv_cnt - kv0, vecs[i].exp_kv);
            check($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
        end

        // Partial frame then PS2_CLK held high until the timeout fires
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 5);
        cyc = 0;
        while (!frame_error && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_fe", 32'(frame_error), 32'd1);
        tests++;
        if (cyc < 49985 || cyc > 50000) begin
            fails++;
            $display("FAIL tmo_cycles: got %0d expected 49985..50000", cyc);
        end
        repeat (4) @(negedge clk);
        check("tmo_fe_count", fe_cnt - fe0, 1);
        kv0 = kv_cnt;
        send_frame(8'h43, 1'b0, 1'b0, 11);
        repeat (8) @(negedge clk);
        check("post_tmo_key", 32'(key_pressed), 32'd8);
        check("post_tmo_kv", kv_cnt - kv0, 1);

        // Break prefix plus partial 0x42, then reset mid-frame
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        send_frame(8'h42, 1'b0, 1'b0, 5);
        rst = 1'b1;
        #1;
        check("rst_mid_key", 32'(key_pressed), 32'd31);
        check("rst_mid_kv", 32'(key_valid), 32'd0);
        check("rst_mid_fe", 32'(frame_error), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        kv0 = kv_cnt;
        repeat (30) @(negedge clk);
        check("rst_no_kv", kv_cnt - kv0, 0);
        send_frame(8'h42, 1'b0, 1'b0, 11);
        repeat (8) @(negedge clk);
        check("rst_clean_key", 32'(key_pressed), 32'd9);
        check("rst_clean_kv", kv_cnt - kv0, 1);

        check("pulse_overlap", overlap, 0);
        check("pulse_width", long_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
